// File: rtl/pof_round_pkg.sv
// rtl/pof_round_pkg.sv - shared rounding types and constants
package pof_round_pkg;

    typedef enum logic [1:0] {
        RNE = 2'd0,
        RTZ = 2'd1,
        RUP = 2'd2,
        RDN = 2'd3
    } rnd_mode_t;

    localparam int GRS_W = 3;

endpackage

// File: rtl/grs_round_decide.sv
// rtl/grs_round_decide.sv - combinational round-increment decision from LSB/G/R/S
module grs_round_decide
    import pof_round_pkg::*;
(
    input  logic      i_lsb,
    input  logic      i_g,
    input  logic      i_r,
    input  logic      i_s,
    input  logic      i_sign,
    input  rnd_mode_t i_mode,
    output logic      o_inc,
    output logic      o_inexact
);

    logic w_any;

    assign w_any     = i_g | i_r | i_s;
    assign o_inexact = w_any;

    always_comb begin
        o_inc = 1'b0;
        case (i_mode)
            RNE: o_inc = i_g & (i_r | i_s | i_lsb);
            RTZ: o_inc = 1'b0;
            RUP: o_inc = ~i_sign & w_any;
            RDN: o_inc = i_sign & w_any;
            default: o_inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/grs_rounder.sv
// rtl/grs_rounder.sv - two-stage GRS rounding pipeline with carry renormalise and exponent saturation
module grs_rounder
    import pof_round_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH+GRS_W-1:0] s_mant,
    input  logic [EXP_WIDTH-1:0]        s_exp,
    input  logic                        s_sign,
    input  logic [1:0]                  s_mode,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH-1:0]       m_mant,
    output logic [EXP_WIDTH-1:0]        m_exp,
    output logic                        m_sign,
    output logic                        m_inexact,
    output logic                        m_overflow
);

    logic                  w_adv1;
    logic                  w_adv2;
    logic                  w_inc;
    logic                  w_inexact;
    logic [DATA_WIDTH-1:0] w_mant;
    logic [DATA_WIDTH:0]   w_sum;

    logic                  r_v1;
    logic [DATA_WIDTH:0]   r_sum;
    logic [EXP_WIDTH-1:0]  r_exp;
    logic                  r_sign;
    logic                  r_inexact;

    logic [DATA_WIDTH-1:0] w_mant2;
    logic [EXP_WIDTH-1:0]  w_exp2;
    logic                  w_ovf2;

    // Ready ripples back from the sink so a full pipe still moves every cycle.
    assign w_adv2  = ~m_valid | m_ready;
    assign w_adv1  = ~r_v1 | w_adv2;
    assign s_ready = w_adv1;

    assign w_mant = s_mant[DATA_WIDTH+GRS_W-1:GRS_W];
    assign w_sum  = {1'b0, w_mant} + {{DATA_WIDTH{1'b0}}, w_inc};

    grs_round_decide u_decide (
        .i_lsb     (s_mant[3]),
        .i_g       (s_mant[2]),
        .i_r       (s_mant[1]),
        .i_s       (s_mant[0]),
        .i_sign    (s_sign),
        .i_mode    (rnd_mode_t'(s_mode)),
        .o_inc     (w_inc),
        .o_inexact (w_inexact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_sum     <= '0;
            r_exp     <= '0;
            r_sign    <= 1'b0;
            r_inexact <= 1'b0;
        end else if (w_adv1) begin
            r_v1      <= s_valid;
            r_sum     <= w_sum;
            r_exp     <= s_exp;
            r_sign    <= s_sign;
            r_inexact <= w_inexact;
        end
    end

    // Carry-out means the mantissa rolled over to 1.000...; shift and bump or saturate.
    always_comb begin
        w_mant2 = r_sum[DATA_WIDTH-1:0];
        w_exp2  = r_exp;
        w_ovf2  = 1'b0;
        if (r_sum[DATA_WIDTH]) begin
            if (&r_exp) begin
                w_mant2 = '1;
                w_exp2  = '1;
                w_ovf2  = 1'b1;
            end else begin
                w_mant2 = r_sum[DATA_WIDTH:1];
                w_exp2  = r_exp + {{(EXP_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_mant     <= '0;
            m_exp      <= '0;
            m_sign     <= 1'b0;
            m_inexact  <= 1'b0;
            m_overflow <= 1'b0;
        end else if (w_adv2) begin
            m_valid    <= r_v1;
            m_mant     <= w_mant2;
            m_exp      <= w_exp2;
            m_sign     <= r_sign;
            m_inexact  <= r_inexact;
            m_overflow <= w_ovf2;
        end
    end

endmodule

// File: tb/tb_grs_rounder.sv
// tb/tb_grs_rounder.sv - randomized and directed self-checking bench for grs_rounder
module tb_grs_rounder;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [15:0] mant;
        logic        inexact;
        logic        overflow;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [18:0] s_mant = '0;
    logic [7:0]  s_exp = '0;
    logic        s_sign = 1'b0;
    logic [1:0]  s_mode = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_mant;
    logic [7:0]  m_exp;
    logic        m_sign;
    logic        m_inexact;
    logic        m_overflow;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   lat_check = 1'b0;
    bit   last_acc = 1'b0;
    res_t exp_q[$];
    int   t_q[$];

    grs_rounder #(.DATA_WIDTH(16), .EXP_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_mant     (s_mant),
        .s_exp      (s_exp),
        .s_sign     (s_sign),
        .s_mode     (s_mode),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_mant     (m_mant),
        .m_exp      (m_exp),
        .m_sign     (m_sign),
        .m_inexact  (m_inexact),
        .m_overflow (m_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference: treat GRS as the fraction below the LSB and round the real value.
    function automatic res_t model(input logic [15:0] mant, input logic [2:0] grs,
                                   input logic [7:0] e, input logic sign, input logic [1:0] mode);
        res_t r;
        int   v;
        int   up;
        up = 0;
        case (mode)
            2'd0: up = (grs > 3'd4 || (grs == 3'd4 && mant % 2 == 1)) ? 1 : 0;
            2'd1: up = 0;
            2'd2: up = (!sign && grs != 0) ? 1 : 0;
            default: up = (sign && grs != 0) ? 1 : 0;
        endcase
        v = int'(mant) + up;
        r.sign = sign;
        r.inexact = (grs != 0);
        r.overflow = 1'b0;
        r.exp = e;
        if (v == 65536) begin
            if (e == 8'd255) begin
                r.mant = 16'hFFFF;
                r.overflow = 1'b1;
            end else begin
                r.mant = 16'h8000;
                r.exp = e + 8'd1;
            end
        end else begin
            r.mant = v[15:0];
        end
        return r;
    endfunction

    // One clock: check at negedge, update model queue, advance to posedge+1.
    task automatic cycle();
        res_t obs;
        @(negedge clk);
        check("s_ready", s_ready, (exp_q.size() < 2 || m_ready) ? 1 : 0);
        if (m_valid) begin
            obs = {m_sign, m_exp, m_mant, m_inexact, m_overflow};
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                check("out", obs, exp_q[0]);
                if (m_ready) begin
                    if (lat_check) check("latency", cyc - t_q[0], 2);
                    void'(exp_q.pop_front());
                    void'(t_q.pop_front());
                end
            end
        end
        last_acc = s_valid && s_ready;
        if (last_acc) begin
            exp_q.push_back(model(s_mant[18:3], s_mant[2:0], s_exp, s_sign, s_mode));
            t_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        s_valid = 1'b0;
        m_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic send(input logic [15:0] mant, input logic [2:0] grs, input logic [7:0] e,
                        input logic sign, input logic [1:0] mode);
        int n;
        s_mant = {mant, grs};
        s_exp = e;
        s_sign = sign;
        s_mode = mode;
        s_valid = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 20);
        check("send_timeout", last_acc, 1);
        s_valid = 1'b0;
        drain();
    endtask

    task automatic rand_beat();
        s_mant = {$urandom_range(0, 3) == 0 ? 16'hFFFF : 16'($urandom), 3'($urandom)};
        s_exp  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        s_sign = 1'($urandom);
        s_mode = 2'($urandom);
    endtask

    initial begin
        #12;
        check("rst_m_valid", m_valid, 0);
        check("rst_outputs", {m_mant, m_exp, m_sign, m_inexact, m_overflow}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        check("s_ready_after_reset", s_ready, 1);

        lat_check = 1'b1;
        send(16'h0001, 3'b100, 8'd10, 1'b0, 2'd0);
        send(16'h0002, 3'b100, 8'd10, 1'b0, 2'd0);
        send(16'h0002, 3'b111, 8'd10, 1'b0, 2'd1);
        send(16'hFFFF, 3'b110, 8'd5,  1'b0, 2'd0);
        send(16'hFFFF, 3'b110, 8'hFF, 1'b0, 2'd0);
        send(16'hFFFF, 3'b001, 8'hFE, 1'b0, 2'd2);
        send(16'h0010, 3'b001, 8'd3,  1'b1, 2'd2);
        send(16'h0010, 3'b001, 8'd3,  1'b1, 2'd3);
        send(16'h0010, 3'b001, 8'd3,  1'b0, 2'd2);
        send(16'h0010, 3'b001, 8'd3,  1'b0, 2'd3);
        for (int m = 0; m < 4; m++) send(16'h1235, 3'b000, 8'd7, 1'(m), 2'(m));
        lat_check = 1'b0;

        // Five back-to-back beats with the sink stalled for three cycles.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_mant = {16'(16'h0100 + i), 3'(i + 3)};
            s_exp = 8'(i);
            s_sign = 1'(i);
            s_mode = 2'(i);
            s_valid = 1'b1;
            for (int k = 0; k < 20; k++) begin
                if (i == 2 && k == 1) m_ready = 1'b1;
                cycle();
                if (last_acc) break;
            end
            check("bp_accept", last_acc, 1);
        end
        drain();

        for (int i = 0; i < 600; i++) begin
            if (!(s_valid && !last_acc)) begin
                s_valid = 1'($urandom_range(0, 3) != 0);
                rand_beat();
            end
            m_ready = 1'($urandom_range(0, 2) != 0);
            cycle();
        end
        drain();

        // Reset with two beats in flight.
        m_ready = 1'b0;
        s_valid = 1'b1;
        rand_beat();
        cycle();
        rand_beat();
        cycle();
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_m_valid", m_valid, 0);
        exp_q.delete();
        t_q.delete();
        @(posedge clk);
        #1;
        check("rst_mid_outputs", {m_valid, m_mant, m_exp, m_sign, m_inexact, m_overflow}, 0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        check("s_ready_after_mid_reset", s_ready, 1);
        for (int i = 0; i < 6; i++) cycle();
        check("no_stale_valid", m_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grs_rounder.md
Name: grs_rounder

Overview:
- Pipelined rounding stage that sits directly downstream of the sticky right-shifter.
- Consumes a mantissa extended with Guard/Round/Sticky bits, plus sign and exponent.
- Applies the selected rounding mode and renormalises on carry-out, saturating the exponent on overflow.
- Valid/ready handshake on both sides; 2-cycle latency; full throughput of 1 beat/cycle.

Parameters:
- DATA_WIDTH, 16, mantissa width without GRS bits. Must match the shifter's DATA_WIDTH.
- EXP_WIDTH, 8, unsigned biased exponent width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept an input beat.
- s_mant  in  DATA_WIDTH+3  {mantissa, G, R, S}; bit 0 is S.
- s_exp  in  EXP_WIDTH  exponent of the input beat.
- s_sign  in  1  sign of the input beat (1 = negative).
- s_mode  in  2  rounding mode, sampled with the beat: 0 RNE, 1 RTZ, 2 RUP (toward +inf), 3 RDN (toward -inf).
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts the output beat.
- m_mant  out  DATA_WIDTH  rounded mantissa.
- m_exp  out  EXP_WIDTH  adjusted exponent.
- m_sign  out  1  passthrough sign.
- m_inexact  out  1  set when G|R|S != 0.
- m_overflow  out  1  set when the exponent saturated.

Behaviour:
- Reset: v1, v2, m_valid, m_mant, m_exp, m_sign, m_inexact and m_overflow all clear to 0 asynchronously.
- Reset mid-stream drops all in-flight beats. After release, s_ready is 1 in the first cycle.
- Handshake:
  - A transfer occurs on a cycle where valid & ready are both 1.
  - m_valid must not drop and output data must not change while m_valid=1 and m_ready=0.
  - adv2 = ~v2 | m_ready.
  - adv1 = ~v1 | adv2.
  - s_ready = adv1. This gives a combinational path from m_ready to s_ready.
- Stage 1 (registered when adv1):
  - Decode G/R/S and LSB = s_mant[3].
  - inc rules:
    - RNE: G & (R | S | LSB).
    - RTZ: 0.
    - RUP: ~sign & (G|R|S).
    - RDN: sign & (G|R|S).
  - Compute sum = {1'b0, mant} + inc, DATA_WIDTH+1 bits wide.
  - Register sum, exp, sign, and inexact = |GRS.
  - v1 <= s_valid.
- Stage 2 (registered when adv2):
  - If sum carry bit = 0: mant = sum[DATA_WIDTH-1:0]; exp unchanged.
  - If carry = 1 and exp != all-ones: mant = sum[DATA_WIDTH:1] (MSB=1, rest 0); exp + 1.
  - If carry = 1 and exp == all-ones: mant = all-ones, exp = all-ones, overflow = 1.
  - v2 <= v1.
- Latency: an input accepted in cycle t appears with m_valid=1 at cycle t+2 when there is no backpressure.
- Simultaneous input accept and output drain in the same cycle is legal and keeps full throughput.
- Exact inputs (GRS=000) pass through unchanged with inexact=0 in every mode.

Decomposition:
- Package pof_round_pkg holds:
  - typedef enum logic [1:0] rnd_mode_t {RNE, RTZ, RUP, RDN}.
  - Constant GRS_W = 3.
- Sub-module grs_round_decide: purely combinational. Inputs are lsb, g, r, s, sign and mode; outputs are inc and inexact. It is reused by the future posit rounder.
- The pipeline registers and the handshake logic stay in grs_rounder.

Test Plan:
- RNE tie to odd: mant=0x0001, GRS=100, exp=10, mode RNE -> m_mant=0x0002, exp=10, inexact=1, two cycles after accept.
- RNE tie to even, plus RTZ: mant=0x0002, GRS=100 -> 0x0002, inexact=1. Same beat in RTZ with GRS=111 -> 0x0002.
- Carry renormalise: mant=0xFFFF, GRS=110, exp=5, RNE -> mant=0x8000, exp=6, overflow=0. Same beat with exp=0xFF -> mant=0xFFFF, exp=0xFF, overflow=1.
- Directed modes: sign=1, mant=0x0010, GRS=001.
  - RUP -> 0x0010.
  - RDN -> 0x0011.
  - Repeat with sign=0: RUP -> 0x0011, RDN -> 0x0010.
- Backpressure: stream 5 back-to-back beats while m_ready is held 0 for 3 cycles.
  - s_ready drops only once v1 and v2 are both full.
  - All 5 results appear in order with no loss or duplication.
  - Output data stays stable while stalled.
- Reset mid-operation: assert rst_n=0 with two beats in flight -> m_valid=0 immediately. After release s_ready=1 and no stale beat is emitted.
